// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall controller.
package pipe_ctrl_pkg;

    localparam int DEF_MAC_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_BUB   = 2'd1,
        MAC_BUSY = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_bubble;
        logic mac_start;
    } ctrl_t;

    function automatic logic load_use_hazard(
        input logic [4:0] rd, rs1, rs2,
        input logic       ld, reg_wr, use1, use2
    );
        return ld & reg_wr & (rd != 5'd0) &
               ((use1 & (rd == rs1)) | (use2 & (rd == rs2)));
    endfunction

endpackage

// File: rtl/stall_counter.sv
// Saturating stall-cycle counter; synchronous clear beats increment.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Five-stage pipeline hazard/stall controller: branch flush, load-use bubble,
// multi-cycle MAC wait with timeout, and global freeze on data-memory wait.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MAC_TIMEOUT = DEF_MAC_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_ex,
    input  logic             RegWrite_ex,
    input  logic             LoadSel_ex,
    input  logic             PCSel,
    input  logic             mac_ex,
    input  logic             mac_done,
    input  logic             dmem_ready,
    input  logic             stall_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             mac_start,
    output logic             mac_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int TO_W = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MAC_TIMEOUT - 1);

    localparam ctrl_t C_NORM  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t C_MAC   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t C_RESET = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    state_e          state, state_nxt;
    logic [TO_W-1:0] tmo_cnt, tmo_nxt;
    logic            done_pend, pend_nxt, err_nxt;
    logic            hazard, stall_inc;
    ctrl_t           ctl;

    assign hazard = load_use_hazard(rd_ex, rs1_ID, rs2_ID, LoadSel_ex, RegWrite_ex,
                                    use_rs1_ID, use_rs2_ID);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            tmo_cnt   <= '0;
            done_pend <= 1'b0;
            mac_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_nxt;
            done_pend <= pend_nxt;
            mac_err   <= err_nxt;
        end
    end

    always_comb begin
        ctl       = C_NORM;
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        pend_nxt  = done_pend;
        err_nxt   = mac_err;
        if (!reset_n) begin
            ctl = C_RESET;
        end else if (!dmem_ready) begin
            // Whole pipe waits on memory; a MAC completion seen now is remembered.
            ctl = '0;
            if ((state == MAC_BUSY) && mac_done)
                pend_nxt = 1'b1;
        end else begin
            unique case (state)
                RUN, LD_BUB: begin
                    state_nxt = RUN;
                    if (PCSel) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end else if (mac_ex) begin
                        ctl           = C_MAC;
                        ctl.mac_start = 1'b1;
                        tmo_nxt       = '0;
                        state_nxt     = MAC_BUSY;
                    end else if (hazard && (state == RUN)) begin
                        ctl.pc_en      = 1'b0;
                        ctl.ifid_en    = 1'b0;
                        ctl.idex_flush = 1'b1;
                        state_nxt      = LD_BUB;
                    end
                end
                MAC_BUSY: begin
                    if (mac_done || done_pend) begin
                        pend_nxt  = 1'b0;
                        state_nxt = RUN;
                    end else if (tmo_cnt == TO_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        ctl     = C_MAC;
                        tmo_nxt = tmo_cnt + 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign pc_en        = ctl.pc_en;
    assign ifid_en      = ctl.ifid_en;
    assign idex_en      = ctl.idex_en;
    assign exmem_en     = ctl.exmem_en;
    assign memwb_en     = ctl.memwb_en;
    assign ifid_flush   = ctl.ifid_flush;
    assign idex_flush   = ctl.idex_flush;
    assign exmem_bubble = ctl.exmem_bubble;
    assign mac_start    = ctl.mac_start;
    assign stall_inc    = ~ctl.pc_en;

    stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .clr     (stall_clr),
        .count   (stall_count)
    );

endmodule
